caravel_ips_wb_splitter: RTL and testbench

- Wishbone slave-side splitter/sequencer between the management SoC Wishbone port of the user area and NUM_SLAVES IP slaves inside caravel_ips.
- Decodes the address and forwards one transaction at a time to the selected slave.
- Sequences the handshake and returns data and ack to the master.
- Guards against hung slaves and unmapped addresses with a timeout/error response, so the management core never stalls.

---
 rtl/caravel_ips_wb_splitter_if.sv | 30 +++
 rtl/caravel_ips_wb_splitter.sv | 116 +++++++++++
 tb/tb_caravel_ips_wb_splitter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/caravel_ips_wb_splitter_if.sv
// caravel_ips_wb_splitter_if: management-side Wishbone port plus the shared/one-hot IP slave bus
interface caravel_ips_wb_splitter_if #(
  parameter int NUM_SLAVES = 4,
  parameter int SLAVE_AW = 16
);
  logic wbs_cyc_i;
  logic wbs_stb_i;
  logic wbs_we_i;
  logic [3:0] wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [NUM_SLAVES-1:0] s_cyc_o;
  logic [NUM_SLAVES-1:0] s_stb_o;
  logic s_we_o;
  logic [3:0] s_sel_o;
  logic [SLAVE_AW-1:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [32*NUM_SLAVES-1:0] s_dat_i;
  logic [NUM_SLAVES-1:0] s_ack_i;
  modport slave (
    input wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, s_dat_i, s_ack_i,
    output wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, s_dat_i, s_ack_i,
    input wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );
endinterface

// File: rtl/caravel_ips_wb_splitter.sv
// caravel_ips_wb_splitter: decodes the user Wishbone window and runs one transaction at a time to an IP slave, with timeout/error response
module caravel_ips_wb_splitter #(
  parameter int NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int SLAVE_AW = 16,
  parameter int TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  caravel_ips_wb_splitter_if.slave bus,
  input logic err_clr_i,
  output logic err_o,
  output logic [IW-1:0] err_slot_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, cnt_inc;
  logic [IW-1:0] slot, slot_q, slot_n, err_slot_n;
  logic hit, err_set, ack_n, we_n;
  logic [NUM_SLAVES-1:0] sel_oh, stb_n;
  logic [3:0] bsel_n;
  logic [SLAVE_AW-1:0] adr_n;
  logic [31:0] wdat_n, rdat_n;
  assign slot = bus.wbs_adr_i[SLAVE_AW+IW-1:SLAVE_AW];
  assign hit = (bus.wbs_adr_i[31:SLAVE_AW+IW] == BASE_ADDR[31:SLAVE_AW+IW]) && (int'(slot) < NUM_SLAVES);
  assign sel_oh = NUM_SLAVES'(1) << slot;
  assign cnt_inc = (cnt == 16'(TIMEOUT)) ? cnt : cnt + 16'd1;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    slot_n = slot_q;
    stb_n = bus.s_stb_o;
    we_n = bus.s_we_o;
    bsel_n = bus.s_sel_o;
    adr_n = bus.s_adr_o;
    wdat_n = bus.s_dat_o;
    ack_n = 1'b0;
    rdat_n = '0;
    err_set = 1'b0;
    err_slot_n = err_slot_o;
    case (state)
      IDLE: if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
        we_n = bus.wbs_we_i;
        bsel_n = bus.wbs_sel_i;
        adr_n = bus.wbs_adr_i[SLAVE_AW-1:0];
        wdat_n = bus.wbs_dat_i;
        slot_n = slot;
        if (hit) begin
          stb_n = sel_oh;
          cnt_n = '0;
          state_n = BUSY;
        end else begin
          ack_n = 1'b1;
          rdat_n = ERR_DATA;
          err_set = 1'b1;
          err_slot_n = '0;
          state_n = DONE;
        end
      end
      BUSY: begin
        cnt_n = cnt_inc;
        // abort beats ack, and ack beats a timeout landing in the same cycle
        if (!bus.wbs_cyc_i) begin
          stb_n = '0;
          state_n = IDLE;
        end else if (bus.s_ack_i[slot_q]) begin
          stb_n = '0;
          ack_n = 1'b1;
          rdat_n = bus.s_dat_i[32*int'(slot_q) +: 32];
          state_n = DONE;
        end else if (cnt_inc == 16'(TIMEOUT)) begin
          stb_n = '0;
          ack_n = 1'b1;
          rdat_n = ERR_DATA;
          err_set = 1'b1;
          err_slot_n = slot_q;
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
      slot_q <= '0;
      bus.s_cyc_o <= '0;
      bus.s_stb_o <= '0;
      bus.s_we_o <= 1'b0;
      bus.s_sel_o <= '0;
      bus.s_adr_o <= '0;
      bus.s_dat_o <= '0;
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
      err_o <= 1'b0;
      err_slot_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      slot_q <= slot_n;
      bus.s_cyc_o <= stb_n;
      bus.s_stb_o <= stb_n;
      bus.s_we_o <= we_n;
      bus.s_sel_o <= bsel_n;
      bus.s_adr_o <= adr_n;
      bus.s_dat_o <= wdat_n;
      bus.wbs_ack_o <= ack_n;
      bus.wbs_dat_o <= rdat_n;
      err_o <= err_set | (err_o & ~err_clr_i);
      err_slot_o <= err_slot_n;
    end
endmodule

// File: tb/tb_caravel_ips_wb_splitter.sv
// tb_caravel_ips_wb_splitter: directed and random transactions checked against a transaction-level model of the splitter
module tb_caravel_ips_wb_splitter;
  localparam int NS = 4;
  localparam int AW = 16;
  localparam int TO = 255;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam int NEVER = 1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_clr = 1'b0;
  logic err_o;
  logic [1:0] err_slot_o;
  int checks = 0;
  int errors = 0;
  logic m_err = 1'b0;
  logic [1:0] m_slot = 2'd0;
  caravel_ips_wb_splitter_if #(.NUM_SLAVES(NS), .SLAVE_AW(AW)) bus ();
  caravel_ips_wb_splitter #(
    .NUM_SLAVES(NS), .BASE_ADDR(BASE), .SLAVE_AW(AW), .TIMEOUT(TO), .ERR_DATA(ERR)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus),
    .err_clr_i(err_clr),
    .err_o(err_o),
    .err_slot_o(err_slot_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // lat = strobe cycle in which the addressed slave acks (0 = first strobe cycle)
  task automatic xact(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                      input logic [3:0] sel, input int lat, input logic [31:0] rd);
    logic hit, clr0, perr;
    int slot, ns;
    logic [3:0] oh;
    logic [31:0] ed;
    hit = (adr - BASE) < (32'(NS) << AW);
    slot = hit ? int'((adr - BASE) >> AW) : 0;
    oh = hit ? 4'(1 << slot) : 4'b0;
    ns = !hit ? 0 : (lat < TO ? lat + 1 : TO);
    ed = (hit && lat < TO) ? rd : ERR;
    clr0 = err_clr;
    if (clr0) m_err = 1'b0;
    perr = m_err;
    if (!hit || lat >= TO) begin
      m_err = 1'b1;
      m_slot = 2'(slot);
    end
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wd;
    bus.s_ack_i = 4'($urandom);
    tick();
    err_clr = 1'b0;
    for (int j = 0; j <= ns; j++) begin
      chk("s_stb", bus.s_stb_o, j < ns ? oh : 4'b0);
      chk("s_cyc", bus.s_cyc_o, j < ns ? oh : 4'b0);
      chk("wbs_ack", bus.wbs_ack_o, j == ns);
      chk("wbs_dat", bus.wbs_dat_o, j == ns ? ed : 32'h0);
      chk("err_o", err_o, j == ns ? m_err : perr);
      if (j < ns) begin
        chk("s_adr", bus.s_adr_o, adr[15:0]);
        chk("s_dat", bus.s_dat_o, wd);
        chk("s_we", bus.s_we_o, we);
        chk("s_sel", bus.s_sel_o, sel);
      end
      for (int k = 0; k < NS; k++) bus.s_dat_i[32*k +: 32] = (k == slot) ? rd : $urandom;
      bus.s_ack_i = (4'($urandom) & ~oh) | (j == lat ? oh : 4'b0);
      if (j == ns) begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.s_ack_i = 4'b0;
      end
      tick();
    end
    chk("post_ack", bus.wbs_ack_o, 1'b0);
    chk("post_dat", bus.wbs_dat_o, 32'h0);
    chk("post_stb", bus.s_stb_o, 4'b0);
    chk("err_o_after", err_o, m_err);
    chk("err_slot", err_slot_o, m_slot);
  endtask
  initial begin
    logic [31:0] a;
    int lat;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.s_dat_i = '0;
    bus.s_ack_i = '0;
    tick();
    tick();
    chk("rst_ack", bus.wbs_ack_o, 1'b0);
    chk("rst_dat", bus.wbs_dat_o, 32'h0);
    chk("rst_stb", bus.s_stb_o, 4'b0);
    chk("rst_cyc", bus.s_cyc_o, 4'b0);
    chk("rst_adr", bus.s_adr_o, 16'h0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_eslot", err_slot_o, 2'd0);
    rst = 1'b0;
    tick();
    xact(1'b1, 32'h3002_0010, 32'h1234_5678, 4'hF, 0, 32'h0BAD_0002);
    xact(1'b0, 32'h3001_0004, 32'h0, 4'hF, 3, 32'hA5A5_0001);
    xact(1'b0, 32'h3005_0000, 32'h0, 4'hF, 0, 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err = 1'b0;
    chk("err_clr", err_o, 1'b0);
    xact(1'b0, 32'h3003_0000, 32'h0, 4'h3, NEVER, 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err = 1'b0;
    chk("err_clr2", err_o, 1'b0);
    err_clr = 1'b1;
    xact(1'b0, 32'h2FFF_FFFC, 32'h0, 4'hF, 0, 32'h0);
    xact(1'b0, 32'h3000_0008, 32'h0, 4'hF, TO - 1, 32'h5555_AAAA);
    // stray ack from slot 0 while slot 2 is busy, then the master aborts
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h3002_0000;
    tick();
    chk("stray_stb0", bus.s_stb_o, 4'b0100);
    bus.s_ack_i = 4'b0001;
    tick();
    bus.s_ack_i = 4'b0;
    chk("stray_stb1", bus.s_stb_o, 4'b0100);
    chk("stray_ack", bus.wbs_ack_o, 1'b0);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    tick();
    chk("abort_stb", bus.s_stb_o, 4'b0);
    chk("abort_cyc", bus.s_cyc_o, 4'b0);
    chk("abort_ack", bus.wbs_ack_o, 1'b0);
    tick();
    chk("abort_ack2", bus.wbs_ack_o, 1'b0);
    xact(1'b0, 32'h3001_0000, 32'h0, 4'hF, 1, 32'h0000_1111);
    // reset in the middle of a busy transaction
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i = 1'b1;
    bus.wbs_dat_i = 32'hCAFE_F00D;
    bus.wbs_adr_i = 32'h3001_00F0;
    tick();
    tick();
    chk("pre_rst_stb", bus.s_stb_o, 4'b0010);
    rst = 1'b1;
    #1;
    chk("arst_stb", bus.s_stb_o, 4'b0);
    chk("arst_cyc", bus.s_cyc_o, 4'b0);
    chk("arst_sdat", bus.s_dat_o, 32'h0);
    chk("arst_adr", bus.s_adr_o, 16'h0);
    chk("arst_err", err_o, 1'b0);
    chk("arst_ack", bus.wbs_ack_o, 1'b0);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    tick();
    rst = 1'b0;
    m_err = 1'b0;
    m_slot = 2'd0;
    tick();
    xact(1'b0, 32'h3001_0004, 32'h0, 4'hF, 0, 32'h7777_0001);
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom
          : BASE + (32'($urandom_range(0, NS - 1)) << AW) + 32'($urandom_range(0, 16'hFFFF));
      lat = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 5);
      err_clr = ($urandom_range(0, 4) == 0);
      xact(1'($urandom), a, $urandom, 4'($urandom), lat, $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
